// File: rtl/mod_add_arb.sv
// -----------------------------------------------------------------------------
// mod_add_arb
//   Shares one mod_add datapath between NUM_REQ requesters. A combinational
//   arbiter grants one requester per cycle. The granted operand triple is
//   reduced by mod_add and the result is captured into a single-entry result
//   buffer. The buffer is returned to the owning requester over a valid/ready
//   channel.
//
//   Build option:
//     MOD_ADD_ARB_RR_EN  defined   : round-robin arbitration (rotating pointer)
//                        undefined : fixed priority, lowest index wins
//
//   Parameters:
//     NUM_REQ      number of requesters (2..8)
//
//   Ports:
//     clk_i        clock, rising edge
//     rst_i        synchronous active-high reset
//     req_valid_i  per-requester operand valid
//     req_ready_o  per-requester operand accepted this cycle (one-hot or zero)
//     req_a_i      operand a, 24 bits per requester
//     req_b_i      operand b, 24 bits per requester
//     req_q_i      modulus q, 23 bits per requester
//     rsp_valid_o  result valid, bit [tag] only
//     rsp_ready_i  per-requester result consumed (only bit [tag] matters)
//     rsp_c_o      shared result data
//
//   Also contains mod_add, the shared datapath:
//     a_i, b_i (24b), q_i (23b) -> c_o (23b) = (a+b) mod q, valid for a,b < q
// -----------------------------------------------------------------------------

module mod_add (
  input  logic [23:0] a_i,
  input  logic [23:0] b_i,
  input  logic [22:0] q_i,
  output logic [22:0] c_o
);

  logic [23:0] sum_s;
  logic [23:0] diff_s;

  // Single conditional subtraction; the sum wraps at 2^24 by design.
  always_comb begin
    sum_s  = a_i + b_i;
    diff_s = sum_s - {1'b0, q_i};
    if (sum_s >= {1'b0, q_i}) begin
      c_o = diff_s[22:0];
    end else begin
      c_o = sum_s[22:0];
    end
  end

endmodule

module mod_add_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*24-1:0] req_a_i,
  input  logic [NUM_REQ*24-1:0] req_b_i,
  input  logic [NUM_REQ*23-1:0] req_q_i,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  input  logic [NUM_REQ-1:0]    rsp_ready_i,
  output logic [22:0]           rsp_c_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [IW-1:0] idx_t;

  // Walk upward from 'start', wrapping at NUM_REQ; returns {found, index}.
  function automatic logic [IW:0] pick_first(input logic [NUM_REQ-1:0] vld,
                                             input idx_t               start);
    logic found;
    idx_t g;
    idx_t cur;
    found = 1'b0;
    g     = '0;
    cur   = start;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && vld[cur]) begin
        found = 1'b1;
        g     = cur;
      end else begin
        found = found;
      end
      if (cur == idx_t'(NUM_REQ - 1)) begin
        cur = '0;
      end else begin
        cur = cur + idx_t'(1);
      end
    end
    return {found, g};
  endfunction

  // Result buffer
  logic        out_valid_q, out_valid_d;
  idx_t        tag_q, tag_d;
  logic [22:0] data_q, data_d;

  // Arbitration / handshake
  idx_t        start_s;
  idx_t        gnt_s;
  logic        any_s;
  logic        free_s;
  logic        drain_s;
  logic        accept_s;

  // Datapath
  logic [23:0] a_s;
  logic [23:0] b_s;
  logic [22:0] q_s;
  logic [22:0] c_s;

`ifdef MOD_ADD_ARB_RR_EN
  idx_t        ptr_q, ptr_d;
  assign start_s = ptr_q;
`else
  assign start_s = '0;
`endif

  assign {any_s, gnt_s} = pick_first(req_valid_i, start_s);

  assign free_s   = !out_valid_q | rsp_ready_i[tag_q];
  assign drain_s  = out_valid_q & rsp_ready_i[tag_q];
  // Reset masks the accept so nothing is handed over during a reset cycle.
  assign accept_s = free_s & any_s & !rst_i;

  genvar k;
  generate
    for (k = 0; k < NUM_REQ; k++) begin : g_port
      assign req_ready_o[k] = accept_s & req_valid_i[k] & (gnt_s == idx_t'(k));
      assign rsp_valid_o[k] = out_valid_q & (tag_q == idx_t'(k));
    end
  endgenerate

  assign rsp_c_o = data_q;

  // Operand mux: route the granted requester's triple to the shared adder.
  always_comb begin
    a_s = '0;
    b_s = '0;
    q_s = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (gnt_s == idx_t'(j)) begin
        a_s = req_a_i[j*24 +: 24];
        b_s = req_b_i[j*24 +: 24];
        q_s = req_q_i[j*23 +: 23];
      end else begin
        a_s = a_s;
      end
    end
  end

  mod_add u_mod_add (
    .a_i (a_s),
    .b_i (b_s),
    .q_i (q_s),
    .c_o (c_s)
  );

  // Buffer next state: accept reloads (even while draining), drain alone empties.
  always_comb begin
    out_valid_d = out_valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      tag_d       = gnt_s;
      data_d      = c_s;
    end else if (drain_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

`ifdef MOD_ADD_ARB_RR_EN
  // Pointer next state: move just past the winner, hold otherwise.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_s) begin
      if (gnt_s == idx_t'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_s + idx_t'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Result buffer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      tag_q       <= '0;
      data_q      <= 23'd0;
    end else begin
      out_valid_q <= out_valid_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: doc/mod_add_arb.md
# mod_add_arb

Round-robin arbiter and single-entry result buffer that shares one `mod_add` datapath between `NUM_REQ` requesters, such as the NTT butterfly sequencer and the core coprocessor port. Each requester issues operand triples `(a, b, q)` over a valid/ready handshake. It receives `(a + b) mod q` one cycle later over its own valid/ready response channel. The block sits between the requester-side controllers and the single shared `mod_add` instance, which it instantiates internally.

## Interface
- `NUM_REQ`, default 2, number of requesters, legal range 2..8.
- `clk_i`  in  1  clock, all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  NUM_REQ  per-requester operand valid.
- `req_ready_o`  out  NUM_REQ  per-requester operand accepted this cycle.
- `req_a_i`  in  NUM_REQ×24  operand a, one 24-bit slice per requester.
- `req_b_i`  in  NUM_REQ×24  operand b, one 24-bit slice per requester.
- `req_q_i`  in  NUM_REQ×23  modulus, one 23-bit slice per requester.
- `rsp_valid_o`  out  NUM_REQ  result valid, at most one bit set at a time.
- `rsp_ready_i`  in  NUM_REQ  per-requester result consumed.
- `rsp_c_o`  out  23  result, shared by all requesters and qualified by `rsp_valid_o`.

## Operation
- **Result buffer.** A single buffer holds `out_valid`, a tag (index of the owning requester) and a 23-bit data field.
- **Free condition.** `free = !out_valid | rsp_ready_i[tag]`.
- **Arbitration.** Arbitration is combinational over `req_valid_i`. The search starts at round-robin pointer `ptr` and walks upward modulo `NUM_REQ`. The first valid index is `gnt`.
- **Ready.** `req_ready_o[k] = free & req_valid_i[k] & (k == gnt)`. Ready is one-hot or zero.
- **Accept.** An accept occurs when `free` holds and some request is valid. On accept:
  - The `gnt` operands drive the `mod_add` inputs.
  - The `mod_add` output is captured into the buffer data field.
  - `tag` is set to `gnt` and `out_valid` is set to 1.
  - `ptr` is set to `(gnt + 1) mod NUM_REQ`.
- **Drain.** A drain occurs when `out_valid` and `rsp_ready_i[tag]` are both high. On a drain with no same-cycle accept, `out_valid` clears.
- **Drain plus accept.** A drain and an accept in the same cycle are legal. The buffer reloads and `out_valid` stays 1.
- **Response outputs.** `rsp_valid_o[tag] = out_valid`, and all other bits are 0. `rsp_c_o` is the buffer data field.
- **Arithmetic.** Arithmetic is exactly that of `mod_add`:
  - `s = (a + b) mod 2^24`.
  - If `s >= {0, q}`, the result is `(s - q)[22:0]`. Otherwise it is `s[22:0]`.
  - A correct residue requires `a, b < q`. This is the requester's responsibility and is not checked.
- **Stability.** While a response is held, `rsp_c_o` and `rsp_valid_o` are stable. Requests that are not granted see `req_ready_o = 0`, and the requester must hold its operands.
- **Ignored bits.** `rsp_ready_i` bits other than `tag` are ignored.

## Timing
- **Reset values.** When `rst_i` is high at an edge, the block sets `out_valid=0`, `tag=0`, data `=0` and `ptr=0`. Consequently:
  - `rsp_valid_o` and `rsp_c_o` are 0.
  - `req_ready_o` is 0 in a reset cycle, which is forced regardless of `free`.
- **Reset mid-operation.** A reset discards any held result; no response is produced for it.
- **Latency.** An accept at edge t makes `rsp_valid_o` visible after edge t, i.e. a latency of 1 cycle.
- **Throughput.** With `rsp_ready_i` held high, throughput is 1 result per cycle.
- **Backpressure.** While the owning requester deasserts `rsp_ready_i`, all `req_ready_o` bits are 0. The pointer holds.
- **Simultaneous requests.** All requesters valid every cycle with responses always consumed gives strict rotation: 0,1,…,`NUM_REQ`-1,0.
- **Lone requester.** A single continuously valid requester is granted every cycle.

## Configuration
- **`MOD_ADD_ARB_RR_EN` defined:** round-robin as described above.
- **`MOD_ADD_ARB_RR_EN` undefined:** fixed priority, lowest index wins.
  - `ptr` is not implemented and the search always starts at 0.
  - All other behaviour, latency and reset values are identical.

## Test plan
- **Reset.** Reset with all requests valid → `req_ready_o=0`, `rsp_valid_o=0`, `rsp_c_o=0`. First grant after release goes to requester 0.
- **Wrap-around.** Requester 1 sends a=8380416, b=1, q=8380417 → one cycle later `rsp_valid_o=2'b10`, `rsp_c_o=0`. Then a=5, b=7, same q → `rsp_c_o=12`.
- **Round-robin.** Both requesters valid for 6 cycles with `rsp_ready_i=2'b11`, RR enabled → grant order 0,1,0,1,0,1. Built without the macro → six grants to requester 0.
- **Backpressure.** Requester 0 result held with `rsp_ready_i[0]=0` for 3 cycles while requester 1 is valid → `req_ready_o=0` throughout and `rsp_c_o` stable. On release, drain and requester 1 accept happen in the same cycle.
- **Reset mid-operation.** Assert `rst_i` while `rsp_valid_o=2'b01` → next cycle `rsp_valid_o=0`, and the pointer returns to 0.
- **Random soak.** Random valid/ready patterns with operands < q=8380417 → each result equals (a+b) mod q, is delivered to the issuing requester, and no response is lost or duplicated.
